// File: rtl/router_pkt_reg.sv
// Router packet register: header/check capture, running check accumulation,
// payload counting and a small skid buffer that holds words while the FIFO is full.
module router_pkt_reg #(
  parameter int DATA_W     = 8,
  parameter int SKID_DEPTH = 2,
  parameter int CHK_MODE   = 0
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                packet_valid,
  input  logic                                fifo_full,
  input  logic                                detect_add,
  input  logic                                lfd_state,
  input  logic                                ld_state,
  input  logic                                laf_state,
  input  logic                                full_state,
  input  logic                                rst_int_reg,
  input  logic [DATA_W-1:0]                   datain,
  output logic [DATA_W-1:0]                   dout,
  output logic                                dout_valid,
  output logic                                err,
  output logic                                len_err,
  output logic                                ovf_err,
  output logic                                parity_done,
  output logic                                low_packet_valid,
  output logic [$clog2(SKID_DEPTH+1)-1:0]     skid_count
);

  localparam int CNT_W = $clog2(SKID_DEPTH+1);
  localparam int LEN_W = DATA_W - 2;

  logic [DATA_W-1:0] header;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] chk_word;
  logic [LEN_W-1:0]  pay_cnt;
  logic [DATA_W-1:0] skid     [SKID_DEPTH];
  logic [DATA_W-1:0] skid_nxt [SKID_DEPTH];
  logic [CNT_W-1:0]  cnt_nxt;

  logic sel_det, sel_lfd, sel_ld, sel_laf;
  logic skid_empty, skid_full;
  logic do_pop, do_push, drop, direct;

  function automatic logic [DATA_W-1:0] chk_op(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    if (CHK_MODE == 1) return a + b;
    else               return a ^ b;
  endfunction

  // State decode: detect_add wins, then lfd > ld > laf.
  assign sel_det = detect_add && packet_valid;
  assign sel_lfd = !sel_det && lfd_state;
  assign sel_ld  = !sel_det && !lfd_state && ld_state;
  assign sel_laf = !sel_det && !lfd_state && !ld_state && laf_state;

  assign skid_empty = (skid_count == '0);
  assign skid_full  = (skid_count == CNT_W'(SKID_DEPTH));
  assign do_pop     = !fifo_full && !skid_empty && (sel_ld || sel_laf);
  assign do_push    = sel_ld && (fifo_full || !skid_empty);
  assign drop       = do_push && skid_full && !do_pop;
  assign direct     = sel_ld && !fifo_full && skid_empty;

  // Skid buffer is a shift register with the oldest word at index 0.
  always_comb begin
    for (int i = 0; i < SKID_DEPTH; i++) skid_nxt[i] = skid[i];
    cnt_nxt = skid_count;
    if (do_pop) begin
      for (int i = 0; i < SKID_DEPTH-1; i++) skid_nxt[i] = skid[i+1];
      skid_nxt[SKID_DEPTH-1] = '0;
      cnt_nxt = skid_count - CNT_W'(1);
    end
    if (do_push && !drop) begin
      for (int i = 0; i < SKID_DEPTH; i++)
        if (i == int'(cnt_nxt)) skid_nxt[i] = datain;
      cnt_nxt = cnt_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      header           <= '0;
      acc              <= '0;
      chk_word         <= '0;
      pay_cnt          <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= '0;
      skid_count       <= '0;
      dout             <= '0;
      dout_valid       <= 1'b0;
      err              <= 1'b0;
      len_err          <= 1'b0;
      ovf_err          <= 1'b0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (sel_det) begin
        header      <= datain;
        acc         <= '0;
        pay_cnt     <= '0;
        for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= '0;
        skid_count  <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        len_err     <= 1'b0;
        ovf_err     <= 1'b0;
      end else begin
        for (int i = 0; i < SKID_DEPTH; i++) skid[i] <= skid_nxt[i];
        skid_count <= cnt_nxt;
        if (sel_lfd) begin
          dout       <= header;
          dout_valid <= 1'b1;
          if (!full_state) acc <= chk_op(acc, header);
        end else if (sel_ld) begin
          if (do_pop) begin
            dout       <= skid[0];
            dout_valid <= 1'b1;
          end else if (direct) begin
            dout       <= datain;
            dout_valid <= 1'b1;
          end
          if (drop) ovf_err <= 1'b1;
          if (packet_valid) begin
            if (!drop) begin
              if (pay_cnt != '1) pay_cnt <= pay_cnt + LEN_W'(1);
              if (!full_state) acc <= chk_op(acc, datain);
            end
          end else begin
            chk_word <= datain;
          end
        end else if (sel_laf && do_pop) begin
          dout       <= skid[0];
          dout_valid <= 1'b1;
        end
        if (parity_done) begin
          err     <= (acc != chk_word);
          len_err <= (pay_cnt != header[DATA_W-1:2]);
        end
        if (low_packet_valid && skid_empty) parity_done <= 1'b1;
      end
      if (rst_int_reg)
        low_packet_valid <= 1'b0;
      else if (sel_ld && !packet_valid)
        low_packet_valid <= 1'b1;
    end
  end

endmodule
